// File: rtl/ifu_fetch_queue_pkg.sv
// ifu_fetch_queue_pkg
// Shared definitions for the queued instruction fetch unit: fetch FSM
// state encoding, instruction word width and the compressed-instruction
// test used when tagging queue entries.
package ifu_fetch_queue_pkg;

    localparam int INST_W = 32;

    typedef enum logic [2:0] {
        S_ISSUE    = 3'd0,
        S_XLATE    = 3'd1,
        S_MEM_REQ  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_DRAIN    = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    // A 16-bit compressed instruction is any encoding whose low two bits
    // are not 2'b11.
    function automatic logic is_rvc(input logic [INST_W-1:0] inst);
        return inst[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/ifu_fetch_queue_fetch_fifo.sv
// ifu_fetch_queue_fetch_fifo
// DEPTH-entry FIFO of fetched instructions, each entry carrying
// {pc, data, rvc, page_fault, access_fault}. No write-to-read bypass:
// a push into an empty FIFO becomes visible on the following cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             drop all entries (overrides push and pop)
//   push, push_*      write one entry at the tail
//   pop               remove the head entry (ignored when empty)
//   count             number of valid entries
//   head_*            fields of the head entry (undefined when count==0)
module ifu_fetch_queue_fetch_fifo
    import ifu_fetch_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [XLEN-1:0]          push_pc,
    input  logic [INST_W-1:0]        push_data,
    input  logic                     push_rvc,
    input  logic                     push_pf,
    input  logic                     push_af,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [XLEN-1:0]          head_pc,
    output logic [INST_W-1:0]        head_data,
    output logic                     head_rvc,
    output logic                     head_pf,
    output logic                     head_af
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] data_mem [DEPTH];
    logic              rvc_mem  [DEPTH];
    logic              pf_mem   [DEPTH];
    logic              af_mem   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (count != '0);
    // Full FIFO may still accept a push when the head leaves the same cycle.
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            pc_mem[wr_ptr]   <= push_pc;
            data_mem[wr_ptr] <= push_data;
            rvc_mem[wr_ptr]  <= push_rvc;
            pf_mem[wr_ptr]   <= push_pf;
            af_mem[wr_ptr]   <= push_af;
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign head_rvc  = rvc_mem[rd_ptr];
    assign head_pf   = pf_mem[rd_ptr];
    assign head_af   = af_mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue
// Instruction fetch unit with a DEPTH-entry instruction queue. Owns the
// fetch PC, optionally translates it through the MMU, issues one icache
// fetch at a time and buffers results for IF/ID via valid/ready.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   redirect_valid_i/_pc_i      flush queue and restart fetch at new PC
//   mmu_enable_i                paging enable, sampled when a fetch starts
//   mmu_req_*/mmu_flush_o       translation request / kill of in-flight one
//   mmu_resp_*                  translation result and page fault
//   mem_req_*                   physical fetch request (held until ready)
//   mem_resp_*                  fetched word and bus error
//   inst_*                      queue head toward IF/ID
module ifu_fetch_queue
    import ifu_fetch_queue_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h3000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    input  logic              mmu_enable_i,
    output logic              mmu_req_valid_o,
    output logic [XLEN-1:0]   mmu_req_vaddr_o,
    output logic              mmu_flush_o,
    input  logic              mmu_resp_valid_i,
    input  logic [XLEN-1:0]   mmu_resp_paddr_i,
    input  logic              mmu_page_fault_i,
    output logic              mem_req_valid_o,
    output logic [XLEN-1:0]   mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_resp_valid_i,
    input  logic [INST_W-1:0] mem_resp_data_i,
    input  logic              mem_resp_err_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [XLEN-1:0]   inst_pc_o,
    output logic [INST_W-1:0] inst_data_o,
    output logic              inst_is_rvc_o,
    output logic              inst_page_fault_o,
    output logic              inst_access_fault_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    state_t            state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   paddr;
    logic              kill_pend;
    logic              flush_q;

    logic [CW-1:0]     q_count;
    logic              q_push;
    logic [INST_W-1:0] q_push_data;
    logic              q_push_pf;
    logic              q_push_af;
    logic              q_pop;
    logic [XLEN-1:0]   head_pc;
    logic [INST_W-1:0] head_data;
    logic              head_rvc;
    logic              head_pf;
    logic              head_af;
    logic              has_room;

    assign has_room = q_count < DEPTH_CNT;

    // Responses that coincide with a redirect belong to the old stream and
    // are never queued.
    always_comb begin
        q_push      = 1'b0;
        q_push_data = '0;
        q_push_pf   = 1'b0;
        q_push_af   = 1'b0;
        if (!redirect_valid_i) begin
            if (state == S_XLATE && mmu_resp_valid_i && mmu_page_fault_i) begin
                q_push    = 1'b1;
                q_push_pf = 1'b1;
            end
            if (state == S_MEM_WAIT && mem_resp_valid_i) begin
                q_push      = 1'b1;
                q_push_data = mem_resp_data_i;
                q_push_af   = mem_resp_err_i;
            end
        end
    end

    assign q_pop = inst_valid_o && inst_ready_i;

    ifu_fetch_queue_fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid_i),
        .push      (q_push),
        .push_pc   (fetch_pc),
        .push_data (q_push_data),
        .push_rvc  (is_rvc(q_push_data)),
        .push_pf   (q_push_pf),
        .push_af   (q_push_af),
        .pop       (q_pop),
        .count     (q_count),
        .head_pc   (head_pc),
        .head_data (head_data),
        .head_rvc  (head_rvc),
        .head_pf   (head_pf),
        .head_af   (head_af)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_ISSUE;
            fetch_pc  <= RESET_PC;
            paddr     <= '0;
            kill_pend <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            flush_q <= redirect_valid_i && (state == S_XLATE);
            if (redirect_valid_i) fetch_pc <= redirect_pc_i;
            case (state)
                S_ISSUE: begin
                    if (!redirect_valid_i && has_room) begin
                        if (mmu_enable_i) begin
                            state <= S_XLATE;
                        end else begin
                            paddr <= fetch_pc;
                            state <= S_MEM_REQ;
                        end
                    end
                end
                S_XLATE: begin
                    if (redirect_valid_i) begin
                        state <= S_ISSUE;
                    end else if (mmu_resp_valid_i) begin
                        if (mmu_page_fault_i) begin
                            state <= S_HALT;
                        end else begin
                            paddr <= mmu_resp_paddr_i;
                            state <= S_MEM_REQ;
                        end
                    end
                end
                S_MEM_REQ: begin
                    // The request cannot be withdrawn; a redirect only marks
                    // its eventual response for discard.
                    if (mem_req_ready_i) begin
                        state     <= (kill_pend || redirect_valid_i) ? S_DRAIN : S_MEM_WAIT;
                        kill_pend <= 1'b0;
                    end else if (redirect_valid_i) begin
                        kill_pend <= 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (redirect_valid_i) begin
                        state <= mem_resp_valid_i ? S_ISSUE : S_DRAIN;
                    end else if (mem_resp_valid_i) begin
                        if (mem_resp_err_i) begin
                            state <= S_HALT;
                        end else begin
                            fetch_pc <= fetch_pc + (is_rvc(mem_resp_data_i) ? XLEN'(2) : XLEN'(4));
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_resp_valid_i) state <= S_ISSUE;
                end
                S_HALT: begin
                    if (redirect_valid_i) state <= S_ISSUE;
                end
                default: state <= S_ISSUE;
            endcase
        end
    end

    assign mmu_req_valid_o = (state == S_XLATE);
    assign mmu_req_vaddr_o = (state == S_XLATE) ? fetch_pc : '0;
    assign mmu_flush_o     = flush_q;
    assign mem_req_valid_o = (state == S_MEM_REQ);
    assign mem_req_addr_o  = (state == S_MEM_REQ) ? paddr : '0;

    // Head fields are forced to zero while the queue is empty so that the
    // unreset entry storage never shows on the outputs.
    assign inst_valid_o        = (q_count != '0);
    assign inst_pc_o           = inst_valid_o ? head_pc   : '0;
    assign inst_data_o         = inst_valid_o ? head_data : '0;
    assign inst_is_rvc_o       = inst_valid_o && head_rvc;
    assign inst_page_fault_o   = inst_valid_o && head_pf;
    assign inst_access_fault_o = inst_valid_o && head_af;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        mmu_enable_i;
    logic        mmu_req_valid_o;
    logic [31:0] mmu_req_vaddr_o;
    logic        mmu_flush_o;
    logic        mmu_resp_valid_i;
    logic [31:0] mmu_resp_paddr_i;
    logic        mmu_page_fault_i;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_ready_i;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        mem_resp_err_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_data_o;
    logic        inst_is_rvc_o;
    logic        inst_page_fault_o;
    logic        inst_access_fault_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        rvc;
        logic        pf;
        logic        af;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        got;
    ent_t        exp_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          resp_delay = 0;
    logic [31:0] rvc_addr = 32'hffff_ffff;
    logic [31:0] r_addr;
    int          r_delay;

    ifu_fetch_queue dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .redirect_valid_i    (redirect_valid_i),
        .redirect_pc_i       (redirect_pc_i),
        .mmu_enable_i        (mmu_enable_i),
        .mmu_req_valid_o     (mmu_req_valid_o),
        .mmu_req_vaddr_o     (mmu_req_vaddr_o),
        .mmu_flush_o         (mmu_flush_o),
        .mmu_resp_valid_i    (mmu_resp_valid_i),
        .mmu_resp_paddr_i    (mmu_resp_paddr_i),
        .mmu_page_fault_i    (mmu_page_fault_i),
        .mem_req_valid_o     (mem_req_valid_o),
        .mem_req_addr_o      (mem_req_addr_o),
        .mem_req_ready_i     (mem_req_ready_i),
        .mem_resp_valid_i    (mem_resp_valid_i),
        .mem_resp_data_i     (mem_resp_data_i),
        .mem_resp_err_i      (mem_resp_err_i),
        .inst_valid_o        (inst_valid_o),
        .inst_ready_i        (inst_ready_i),
        .inst_pc_o           (inst_pc_o),
        .inst_data_o         (inst_data_o),
        .inst_is_rvc_o       (inst_is_rvc_o),
        .inst_page_fault_o   (inst_page_fault_o),
        .inst_access_fault_o (inst_access_fault_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Memory contents: a 4-byte NOP-like word encoding the low address half,
    // except one selectable address that holds a compressed instruction.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == rvc_addr) ? 32'h0000_4501 : {a[15:0], 16'h0013};
    endfunction

    function automatic ent_t mk(input logic [31:0] p, input logic [31:0] d,
                                input logic f_pf, input logic f_af);
        ent_t e;
        e.pc   = p;
        e.data = d;
        e.rvc  = (d[1:0] != 2'b11);
        e.pf   = f_pf;
        e.af   = f_af;
        return e;
    endfunction

    // Icache responder: answers each accepted request resp_delay cycles
    // after the cycle following acceptance.
    initial begin
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        mem_resp_err_i   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid_o && mem_req_ready_i) begin
                r_addr  = mem_req_addr_o;
                r_delay = resp_delay;
                @(posedge clk); #1;
                repeat (r_delay) begin @(posedge clk); #1; end
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = mem_word(r_addr);
                @(posedge clk); #1;
                mem_resp_valid_i = 1'b0;
                mem_resp_data_i  = '0;
            end
        end
    end

    task automatic do_reset();
        rst_n            = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        mmu_enable_i     = 1'b0;
        mmu_resp_valid_i = 1'b0;
        mmu_resp_paddr_i = '0;
        mmu_page_fault_i = 1'b0;
        mem_req_ready_i  = 1'b1;
        inst_ready_i     = 1'b1;
        resp_delay       = 0;
        rvc_addr         = 32'hffff_ffff;
        exp_q.delete();
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        mmu_enable_i     = 1'b0;
        mmu_resp_valid_i = 1'b0;
        mmu_resp_paddr_i = '0;
        mmu_page_fault_i = 1'b0;
        mem_req_ready_i  = 1'b1;
        inst_ready_i     = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({inst_valid_o, mem_req_valid_o, mmu_req_valid_o, mmu_flush_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valids: got %b expected 0000",
                     {inst_valid_o, mem_req_valid_o, mmu_req_valid_o, mmu_flush_o});
        end
        n_checks++;
        if ({mem_req_addr_o, mmu_req_vaddr_o, inst_pc_o, inst_data_o} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_buses: got addr=%h vaddr=%h pc=%h data=%h expected all 0",
                     mem_req_addr_o, mmu_req_vaddr_o, inst_pc_o, inst_data_o);
        end
        n_checks++;
        if ({inst_is_rvc_o, inst_page_fault_o, inst_access_fault_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000",
                     {inst_is_rvc_o, inst_page_fault_o, inst_access_fault_o});
        end
    endtask

    task automatic test_basic();
        int cyc;
        do_reset();
        exp_q.push_back(mk(32'h3000_0000, 32'h0000_0013, 1'b0, 1'b0));
        cyc = 0;
        while (!inst_valid_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                n_checks++;
                if ({mem_req_valid_o, mem_req_addr_o} !== {1'b1, 32'h3000_0000}) begin
                    n_fail++;
                    $display("FAIL basic_first_req: got valid=%b addr=%h expected 1 30000000",
                             mem_req_valid_o, mem_req_addr_o);
                end
            end
        end
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles expected 3", cyc);
        end
        exp_e = exp_q.pop_front();
        got = {inst_pc_o, inst_data_o, inst_is_rvc_o, inst_page_fault_o, inst_access_fault_o};
        n_checks++;
        if (got !== exp_e) begin
            n_fail++;
            $display("FAIL basic_head: got pc=%h data=%h rvc=%b pf=%b af=%b expected pc=%h data=%h rvc=%b pf=%b af=%b",
                     got.pc, got.data, got.rvc, got.pf, got.af,
                     exp_e.pc, exp_e.data, exp_e.rvc, exp_e.pf, exp_e.af);
        end
        @(negedge clk);
        n_checks++;
        if ({mem_req_valid_o, mem_req_addr_o} !== {1'b1, 32'h3000_0004}) begin
            n_fail++;
            $display("FAIL basic_next_req: got valid=%b addr=%h expected 1 30000004",
                     mem_req_valid_o, mem_req_addr_o);
        end
    endtask

    task automatic test_rvc();
        int cyc;
        do_reset();
        rvc_addr = 32'h3000_0000;
        exp_q.push_back(mk(32'h3000_0000, 32'h0000_4501, 1'b0, 1'b0));
        cyc = 0;
        while (!inst_valid_o && cyc < 20) begin @(negedge clk); cyc++; end
        exp_e = exp_q.pop_front();
        got = {inst_pc_o, inst_data_o, inst_is_rvc_o, inst_page_fault_o, inst_access_fault_o};
        n_checks++;
        if (got !== exp_e) begin
            n_fail++;
            $display("FAIL rvc_head: got pc=%h data=%h rvc=%b expected pc=%h data=%h rvc=%b",
                     got.pc, got.data, got.rvc, exp_e.pc, exp_e.data, exp_e.rvc);
        end
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!mem_req_valid_o && cyc < 20);
        n_checks++;
        if ({mem_req_valid_o, mem_req_addr_o} !== {1'b1, 32'h3000_0002}) begin
            n_fail++;
            $display("FAIL rvc_next_req: got valid=%b addr=%h expected 1 30000002",
                     mem_req_valid_o, mem_req_addr_o);
        end
    endtask

    task automatic test_full();
        int acc;
        int cyc;
        do_reset();
        inst_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(32'h3000_0000 + 32'(4 * i), mem_word(32'h3000_0000 + 32'(4 * i)), 1'b0, 1'b0));
        acc = 0;
        repeat (40) begin
            @(negedge clk);
            if (mem_req_valid_o && mem_req_ready_i) acc++;
        end
        n_checks++;
        if (acc != 4) begin
            n_fail++;
            $display("FAIL full_requests: got %0d requests expected 4", acc);
        end
        n_checks++;
        if ({inst_valid_o, mem_req_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_idle: got valid=%b req=%b expected 1 0", inst_valid_o, mem_req_valid_o);
        end
        inst_ready_i = 1'b1;
        exp_e = exp_q.pop_front();
        got = {inst_pc_o, inst_data_o, inst_is_rvc_o, inst_page_fault_o, inst_access_fault_o};
        n_checks++;
        if (got !== exp_e) begin
            n_fail++;
            $display("FAIL full_pop_head: got pc=%h data=%h expected pc=%h data=%h",
                     got.pc, got.data, exp_e.pc, exp_e.data);
        end
        @(negedge clk);
        inst_ready_i = 1'b0;
        exp_q.push_back(mk(32'h3000_0010, mem_word(32'h3000_0010), 1'b0, 1'b0));
        acc = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req_valid_o && mem_req_ready_i) acc++;
        end
        n_checks++;
        if (acc != 1) begin
            n_fail++;
            $display("FAIL full_refill: got %0d requests expected 1", acc);
        end
        inst_ready_i = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 30) begin
            if (inst_valid_o) begin
                exp_e = exp_q.pop_front();
                got = {inst_pc_o, inst_data_o, inst_is_rvc_o, inst_page_fault_o, inst_access_fault_o};
                n_checks++;
                if (got !== exp_e) begin
                    n_fail++;
                    $display("FAIL full_drain: got pc=%h data=%h expected pc=%h data=%h",
                             got.pc, got.data, exp_e.pc, exp_e.data);
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain_timeout: got %0d entries left expected 0", exp_q.size());
        end
    endtask

    task automatic test_page_fault();
        int cyc;
        int bad;
        do_reset();
        mmu_enable_i     = 1'b1;
        inst_ready_i     = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_1000;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        cyc = 0;
        while (!mmu_req_valid_o && cyc < 20) begin @(negedge clk); cyc++; end
        n_checks++;
        if ({mmu_req_valid_o, mmu_req_vaddr_o} !== {1'b1, 32'h8000_1000}) begin
            n_fail++;
            $display("FAIL pf_xlate_req: got valid=%b vaddr=%h expected 1 80001000",
                     mmu_req_valid_o, mmu_req_vaddr_o);
        end
        mmu_resp_valid_i = 1'b1;
        mmu_page_fault_i = 1'b1;
        exp_q.push_back(mk(32'h8000_1000, 32'h0, 1'b1, 1'b0));
        @(negedge clk);
        mmu_resp_valid_i = 1'b0;
        mmu_page_fault_i = 1'b0;
        exp_e = exp_q.pop_front();
        got = {inst_pc_o, inst_data_o, inst_is_rvc_o, inst_page_fault_o, inst_access_fault_o};
        n_checks++;
        if ({inst_valid_o, got} !== {1'b1, exp_e}) begin
            n_fail++;
            $display("FAIL pf_head: got valid=%b pc=%h data=%h pf=%b af=%b expected 1 pc=%h data=%h pf=%b af=%b",
                     inst_valid_o, got.pc, got.data, got.pf, got.af,
                     exp_e.pc, exp_e.data, exp_e.pf, exp_e.af);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req_valid_o || mmu_req_valid_o) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL pf_halt: got %0d request cycles expected 0", bad);
        end
        inst_ready_i     = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_2000;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        n_checks++;
        if (inst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pf_flush: got inst_valid=%b expected 0", inst_valid_o);
        end
        cyc = 0;
        while (!mmu_req_valid_o && cyc < 20) begin @(negedge clk); cyc++; end
        n_checks++;
        if ({mmu_req_valid_o, mmu_req_vaddr_o} !== {1'b1, 32'h8000_2000}) begin
            n_fail++;
            $display("FAIL pf_resume_xlate: got valid=%b vaddr=%h expected 1 80002000",
                     mmu_req_valid_o, mmu_req_vaddr_o);
        end
        mmu_resp_valid_i = 1'b1;
        mmu_resp_paddr_i = 32'h0000_2000;
        exp_q.push_back(mk(32'h8000_2000, mem_word(32'h0000_2000), 1'b0, 1'b0));
        @(negedge clk);
        mmu_resp_valid_i = 1'b0;
        n_checks++;
        if ({mem_req_valid_o, mem_req_addr_o} !== {1'b1, 32'h0000_2000}) begin
            n_fail++;
            $display("FAIL pf_resume_mem: got valid=%b addr=%h expected 1 00002000",
                     mem_req_valid_o, mem_req_addr_o);
        end
        cyc = 0;
        while (!inst_valid_o && cyc < 20) begin @(negedge clk); cyc++; end
        exp_e = exp_q.pop_front();
        got = {inst_pc_o, inst_data_o, inst_is_rvc_o, inst_page_fault_o, inst_access_fault_o};
        n_checks++;
        if (got !== exp_e) begin
            n_fail++;
            $display("FAIL pf_resume_head: got pc=%h data=%h pf=%b expected pc=%h data=%h pf=%b",
                     got.pc, got.data, got.pf, exp_e.pc, exp_e.data, exp_e.pf);
        end
    endtask

    task automatic test_xlate_flush();
        int cyc;
        do_reset();
        mmu_enable_i = 1'b1;
        cyc = 0;
        while (!mmu_req_valid_o && cyc < 20) begin @(negedge clk); cyc++; end
        n_checks++;
        if ({mmu_req_valid_o, mmu_req_vaddr_o} !== {1'b1, 32'h3000_0000}) begin
            n_fail++;
            $display("FAIL flush_xlate_req: got valid=%b vaddr=%h expected 1 30000000",
                     mmu_req_valid_o, mmu_req_vaddr_o);
        end
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h3000_0200;
        mmu_resp_valid_i = 1'b1;
        mmu_resp_paddr_i = 32'hdead_0000;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        mmu_resp_valid_i = 1'b0;
        n_checks++;
        if ({mmu_flush_o, mmu_req_valid_o, mem_req_valid_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL flush_pulse: got flush=%b mmu_req=%b mem_req=%b expected 1 0 0",
                     mmu_flush_o, mmu_req_valid_o, mem_req_valid_o);
        end
        @(negedge clk);
        n_checks++;
        if (mmu_flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_one_cycle: got flush=%b expected 0", mmu_flush_o);
        end
        cyc = 0;
        while (!mmu_req_valid_o && cyc < 20) begin @(negedge clk); cyc++; end
        n_checks++;
        if ({mmu_req_valid_o, mmu_req_vaddr_o} !== {1'b1, 32'h3000_0200}) begin
            n_fail++;
            $display("FAIL flush_restart: got valid=%b vaddr=%h expected 1 30000200",
                     mmu_req_valid_o, mmu_req_vaddr_o);
        end
    endtask

    task automatic test_redirect_wait();
        int cyc;
        do_reset();
        inst_ready_i = 1'b0;
        resp_delay   = 4;
        cyc = 0;
        while (!inst_valid_o && cyc < 30) begin @(negedge clk); cyc++; end
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!mem_req_valid_o && cyc < 30);
        @(negedge clk);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h3000_0100;
        resp_delay       = 0;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        n_checks++;
        if (inst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_queue_clear: got inst_valid=%b expected 0", inst_valid_o);
        end
        cyc = 0;
        while (!mem_req_valid_o && cyc < 30) begin @(negedge clk); cyc++; end
        n_checks++;
        if ({mem_req_valid_o, mem_req_addr_o} !== {1'b1, 32'h3000_0100}) begin
            n_fail++;
            $display("FAIL redir_next_req: got valid=%b addr=%h expected 1 30000100",
                     mem_req_valid_o, mem_req_addr_o);
        end
        exp_q.push_back(mk(32'h3000_0100, mem_word(32'h3000_0100), 1'b0, 1'b0));
        cyc = 0;
        while (!inst_valid_o && cyc < 30) begin @(negedge clk); cyc++; end
        exp_e = exp_q.pop_front();
        got = {inst_pc_o, inst_data_o, inst_is_rvc_o, inst_page_fault_o, inst_access_fault_o};
        n_checks++;
        if (got !== exp_e) begin
            n_fail++;
            $display("FAIL redir_head: got pc=%h data=%h expected pc=%h data=%h",
                     got.pc, got.data, exp_e.pc, exp_e.data);
        end
    endtask

    task automatic test_reset_midwait();
        int cyc;
        do_reset();
        inst_ready_i = 1'b0;
        cyc = 0;
        while (!inst_valid_o && cyc < 30) begin @(negedge clk); cyc++; end
        resp_delay = 3;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!mem_req_valid_o && cyc < 30);
        @(posedge clk); #2;
        n_checks++;
        if ({inst_valid_o, mem_req_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL midwait_pre: got valid=%b req=%b expected 1 0", inst_valid_o, mem_req_valid_o);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({inst_valid_o, mem_req_valid_o, mmu_req_valid_o, mmu_flush_o, mem_req_addr_o,
             mmu_req_vaddr_o, inst_pc_o, inst_data_o, inst_is_rvc_o, inst_page_fault_o,
             inst_access_fault_o} !== 135'h0) begin
            n_fail++;
            $display("FAIL midwait_async_reset: got valid=%b pc=%h data=%h addr=%h expected all 0",
                     inst_valid_o, inst_pc_o, inst_data_o, mem_req_addr_o);
        end
        repeat (8) @(negedge clk);
        resp_delay = 0;
        rst_n = 1'b1;
        cyc = 0;
        while (!mem_req_valid_o && cyc < 30) begin @(negedge clk); cyc++; end
        n_checks++;
        if ({mem_req_valid_o, mem_req_addr_o} !== {1'b1, 32'h3000_0000}) begin
            n_fail++;
            $display("FAIL midwait_restart: got valid=%b addr=%h expected 1 30000000",
                     mem_req_valid_o, mem_req_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rvc();
        test_full();
        test_page_fault();
        test_xlate_flush();
        test_redirect_wait();
        test_reset_midwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
Parametrised successor to the single-slot IFU. It owns the fetch PC, translates it through the MMU when paging is on, and issues one instruction fetch at a time. Fetched instructions are buffered in a DEPTH-entry queue, tagged with PC, RVC flag and fault bits, so IF/ID consumes them through a valid/ready handshake instead of a global stall. It sits between pc redirect logic (ex/csr), the MMU, the icache port and the IF/ID register.

Parameters:
XLEN, 32, address/data width
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 32'h3000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
redirect_valid_i  in  1  flush and restart at redirect_pc_i
redirect_pc_i  in  XLEN  new fetch PC (halfword-aligned)
mmu_enable_i  in  1  paging on; sampled at start of each fetch
mmu_req_valid_o  out  1  translation request, held until response
mmu_req_vaddr_o  out  XLEN  virtual PC
mmu_flush_o  out  1  one-cycle kill of in-flight translation
mmu_resp_valid_i  in  1  translation done
mmu_resp_paddr_i  in  XLEN  physical address
mmu_page_fault_i  in  1  qualifies mmu_resp_valid_i
mem_req_valid_o  out  1  fetch request
mem_req_addr_o  out  XLEN  physical fetch address
mem_req_ready_i  in  1  request accepted
mem_resp_valid_i  in  1  fetch data valid
mem_resp_data_i  in  32  instruction word (low half at addr)
mem_resp_err_i  in  1  bus error, qualifies mem_resp_valid_i
inst_valid_o  out  1  queue head valid
inst_ready_i  in  1  IF/ID accepts head
inst_pc_o  out  XLEN  head PC
inst_data_o  out  32  head instruction
inst_is_rvc_o  out  1  head data[1:0]!=2'b11
inst_page_fault_o  out  1  head carries instruction page fault
inst_access_fault_o  out  1  head carries instruction access fault

Behaviour:
- Reset: all outputs 0, queue empty, fetch_pc=RESET_PC, state ISSUE.
- States: ISSUE, XLATE, MEM_REQ, MEM_WAIT, DRAIN, HALT.
- ISSUE: if count<DEPTH: mmu_enable_i ? XLATE : MEM_REQ with paddr=fetch_pc. Else stay.
- XLATE: mmu_req_valid_o=1, vaddr=fetch_pc. On resp: fault -> push {pc, data=0, page_fault=1}, HALT; else latch paddr, MEM_REQ.
- MEM_REQ: mem_req_valid_o=1, addr stable until ready; never withdrawn. On ready -> MEM_WAIT.
- MEM_WAIT: on resp: push {pc, data, rvc, access_fault=err}; err -> HALT; else fetch_pc += rvc?2:4 (mod 2^XLEN), ISSUE.
- HALT: no requests; only redirect leaves it.
- Push never exceeds DEPTH: issue requires count<DEPTH and one request outstanding.
- Queue: pop when inst_valid_o&&inst_ready_i; push and pop same cycle allowed when full or empty (empty: data appears next cycle, no bypass). Fetch-to-inst_valid_o latency with mmu off and zero-wait memory: 3 cycles (ISSUE, MEM_REQ, MEM_WAIT->push).
- Redirect (highest priority, any state): queue cleared that cycle (inst_valid_o=0 next cycle, same-cycle pop ignored); fetch_pc=redirect_pc_i.
  - ISSUE/HALT/XLATE -> ISSUE; XLATE also pulses mmu_flush_o; a response arriving the same cycle is discarded.
  - MEM_REQ: request completes (held until ready), then DRAIN.
  - MEM_WAIT: DRAIN; response arriving the same cycle is discarded, go straight to ISSUE.
- DRAIN: discard one mem response, then ISSUE. A second redirect in DRAIN only updates fetch_pc.
- mmu_enable_i change mid-fetch has no effect until the next ISSUE.

Decomposition:
- Shared package / sysconfig: state encoding constants, queue entry field widths, RVC test macro.
- Sub-module fetch_fifo (parametric DEPTH x {pc, data, rvc, pf, af}) with count, push, pop, flush.

Test Plan:
- Reset, mmu off, mem ready=1, 1-cycle response data 32'h00000013, inst_ready_i=1 -> inst_valid_o at cycle 3, pc 0x30000000; next request addr 0x30000004.
- Response data 32'h4501 (RVC) -> inst_is_rvc_o=1; next mem_req_addr_o=0x30000002.
- inst_ready_i=0, DEPTH=4 -> exactly 4 pushes, no 5th mem_req_valid_o; one pop -> one new request.
- Mmu on, resp page_fault=1 at vaddr 0x80001000 -> head pf=1, pc 0x80001000, no mem request; redirect 0x80002000 -> fetch resumes there.
- Redirect to 0x30000100 while MEM_WAIT -> queue empty next cycle; stale response discarded; next request addr 0x30000100.
- Assert rst_n low during MEM_WAIT -> all outputs 0 immediately; after release first request addr RESET_PC.
